// File: rtl/pll_mode_ctrl_if.sv
// Mode-change request handshake between a system controller and pll_mode_ctrl.
interface pll_mode_ctrl_if;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic       req_err;

    modport master (
        output req_valid,
        output req_mode,
        input  req_ready,
        input  req_err
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ready,
        output req_err
    );
endinterface

// File: rtl/pll_mode_ctrl.sv
// Run-time rPLL controller: programs dynamic divider selects per video mode and
// sequences PLL reset, lock debounce, timeout/retry and the video-domain reset.
module pll_mode_ctrl #(
    parameter int          NUM_MODES     = 2,
    parameter logic [23:0] MODE_FBDIV    = {12'd0, 6'd54, 6'd13},
    parameter logic [23:0] MODE_IDIV     = {12'd0, 6'd3, 6'd2},
    parameter logic [23:0] MODE_ODSEL    = {12'd0, 6'd62, 6'd62},
    parameter int          DEFAULT_MODE  = 1,
    parameter int          RST_CYCLES    = 64,
    parameter int          STABLE_CYCLES = 1024,
    parameter int          LOCK_TIMEOUT  = 27000,
    parameter int          MAX_RETRY     = 3
) (
    input  logic           clk,
    input  logic           resetn,
    pll_mode_ctrl_if.slave req,
    input  logic           pll_lock,
    output logic           pll_reset,
    output logic [5:0]     fbdsel,
    output logic [5:0]     idsel,
    output logic [5:0]     odsel,
    output logic [1:0]     mode_cur,
    output logic           locked,
    output logic           video_resetn,
    output logic           fail
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY) + 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [2:0]       NUM_M     = 3'(NUM_MODES);
    localparam logic [1:0]       DEF_MODE  = 2'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    function automatic logic [5:0] mode_field(input logic [23:0] tbl, input logic [1:0] m);
        case (m)
            2'd0:    mode_field = tbl[5:0];
            2'd1:    mode_field = tbl[11:6];
            2'd2:    mode_field = tbl[17:12];
            default: mode_field = tbl[23:18];
        endcase
    endfunction

    // rPLL dynamic selects are inverted: select code = 63 - divider value.
    function automatic logic [5:0] inv_sel(input logic [5:0] v);
        inv_sel = 6'd63 - v;
    endfunction

    state_t             state;
    logic [RST_W-1:0]   rst_cnt;
    logic [STB_W-1:0]   stb_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RTY_W-1:0]   retry_cnt;
    logic               lock_meta;
    logic               lock_s;
    logic               req_bad;
    logic               req_ok;

    assign req_bad = req.req_valid & req.req_ready & ({1'b0, req.req_mode} >= NUM_M);
    assign req_ok  = req.req_valid & req.req_ready & ~({1'b0, req.req_mode} >= NUM_M);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_RESET;
            rst_cnt       <= '0;
            stb_cnt       <= '0;
            tmo_cnt       <= '0;
            retry_cnt     <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            pll_reset     <= 1'b1;
            video_resetn  <= 1'b0;
            locked        <= 1'b0;
            fail          <= 1'b0;
            req.req_ready <= 1'b0;
            req.req_err   <= 1'b0;
            mode_cur      <= DEF_MODE;
            fbdsel        <= inv_sel(mode_field(MODE_FBDIV, DEF_MODE));
            idsel         <= inv_sel(mode_field(MODE_IDIV, DEF_MODE));
            odsel         <= mode_field(MODE_ODSEL, DEF_MODE);
        end else begin
            lock_meta   <= pll_lock;
            lock_s      <= lock_meta;
            // pll_reset trails the state by one edge so it rises after the accept edge.
            pll_reset   <= (state == ST_RESET);
            req.req_err <= req_bad;

            if (req_ok) begin
                mode_cur      <= req.req_mode;
                fbdsel        <= inv_sel(mode_field(MODE_FBDIV, req.req_mode));
                idsel         <= inv_sel(mode_field(MODE_IDIV, req.req_mode));
                odsel         <= mode_field(MODE_ODSEL, req.req_mode);
                state         <= ST_RESET;
                rst_cnt       <= '0;
                retry_cnt     <= '0;
                fail          <= 1'b0;
                locked        <= 1'b0;
                video_resetn  <= 1'b0;
                req.req_ready <= 1'b0;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (rst_cnt == RST_LAST) begin
                            state   <= ST_WAIT_LOCK;
                            tmo_cnt <= '0;
                        end else begin
                            rst_cnt <= rst_cnt + RST_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state   <= ST_STABLE;
                            stb_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            if (retry_cnt < RTY_MAX) begin
                                retry_cnt <= retry_cnt + RTY_W'(1);
                                state     <= ST_RESET;
                                rst_cnt   <= '0;
                            end else begin
                                state         <= ST_FAIL;
                                fail          <= 1'b1;
                                req.req_ready <= 1'b1;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        // Timeout budget keeps running across lock glitches.
                        if (!lock_s) begin
                            state <= ST_WAIT_LOCK;
                        end else if (stb_cnt == STB_LAST) begin
                            state         <= ST_RUN;
                            retry_cnt     <= '0;
                            locked        <= 1'b1;
                            video_resetn  <= 1'b1;
                            req.req_ready <= 1'b1;
                        end else begin
                            stb_cnt <= stb_cnt + STB_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state         <= ST_RESET;
                            rst_cnt       <= '0;
                            retry_cnt     <= '0;
                            locked        <= 1'b0;
                            video_resetn  <= 1'b0;
                            req.req_ready <= 1'b0;
                        end
                    end
                    ST_FAIL: begin
                    end
                    default: begin
                        state <= ST_RESET;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Directed bench for pll_mode_ctrl with short reset/stable/timeout limits.
module tb_pll_mode_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] fbdsel;
    logic [5:0] idsel;
    logic [5:0] odsel;
    logic [1:0] mode_cur;
    logic       locked;
    logic       video_resetn;
    logic       fail;

    int n_chk = 0;
    int n_err = 0;

    pll_mode_ctrl_if rq ();

    pll_mode_ctrl #(
        .RST_CYCLES   (4),
        .STABLE_CYCLES(8),
        .LOCK_TIMEOUT (50),
        .MAX_RETRY    (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (rq),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .fbdsel      (fbdsel),
        .idsel       (idsel),
        .odsel       (odsel),
        .mode_cur    (mode_cur),
        .locked      (locked),
        .video_resetn(video_resetn),
        .fail        (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n active edges; inputs and samples sit 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset), 1);
        check({tag, "_vresetn"}, 32'(video_resetn), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_ready"}, 32'(rq.req_ready), 0);
        check({tag, "_err"}, 32'(rq.req_err), 0);
        check({tag, "_mode"}, 32'(mode_cur), 1);
        check({tag, "_fbdsel"}, 32'(fbdsel), 9);
        check({tag, "_idsel"}, 32'(idsel), 60);
        check({tag, "_odsel"}, 32'(odsel), 62);
    endtask

    // Called right after the accept edge with pll_lock low: checks the 4-cycle
    // reset pulse, then raises pll_lock and checks the 2+1+8 edge lock latency.
    task automatic relock(input string tag);
        check({tag, "_rst_lag"}, 32'(pll_reset), 0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check({tag, "_rst_hi"}, 32'(pll_reset), 1);
        end
        tick(1);
        check({tag, "_rst_lo"}, 32'(pll_reset), 0);
        pll_lock = 1'b1;
        tick(10);
        check({tag, "_lock_early"}, 32'(locked), 0);
        tick(1);
        check({tag, "_locked"}, 32'(locked), 1);
        check({tag, "_vresetn"}, 32'(video_resetn), 1);
        check({tag, "_ready"}, 32'(rq.req_ready), 1);
    endtask

    task automatic request(input logic [1:0] m);
        rq.req_valid = 1'b1;
        rq.req_mode  = m;
        tick(1);
        rq.req_valid = 1'b0;
    endtask

    initial begin
        int rises;
        int rise_at [3];
        int fail_at;
        logic prev;

        resetn       = 1'b0;
        pll_lock     = 1'b0;
        rq.req_valid = 1'b0;
        rq.req_mode  = 2'd0;
        #23;
        reset_values("por");

        // Power-up with lock arriving 10 cycles after release
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("pwr_rst_hi", 32'(pll_reset), 1);
        end
        tick(1);
        check("pwr_rst_lo", 32'(pll_reset), 0);
        tick(5);
        pll_lock = 1'b1;
        tick(10);
        check("pwr_lock_early", 32'(locked), 0);
        check("pwr_vresetn_early", 32'(video_resetn), 0);
        tick(1);
        check("pwr_locked", 32'(locked), 1);
        check("pwr_vresetn", 32'(video_resetn), 1);
        check("pwr_ready", 32'(rq.req_ready), 1);
        check("pwr_fbdsel", 32'(fbdsel), 9);
        check("pwr_idsel", 32'(idsel), 60);

        // Switch to mode 0; the PLL drops lock while being reprogrammed
        request(2'd0);
        pll_lock = 1'b0;
        check("m0_mode", 32'(mode_cur), 0);
        check("m0_fbdsel", 32'(fbdsel), 50);
        check("m0_idsel", 32'(idsel), 61);
        check("m0_odsel", 32'(odsel), 62);
        check("m0_locked", 32'(locked), 0);
        check("m0_ready", 32'(rq.req_ready), 0);
        relock("m0");

        // Back to mode 1 with a one-cycle lock glitch during STABLE
        request(2'd1);
        pll_lock = 1'b0;
        check("m1_fbdsel", 32'(fbdsel), 9);
        tick(5);
        pll_lock = 1'b1;
        tick(4);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(6);
        check("glitch_not_run", 32'(locked), 0);
        tick(4);
        check("glitch_lock_early", 32'(locked), 0);
        tick(1);
        check("glitch_locked", 32'(locked), 1);

        // Out-of-range requests
        request(2'd3);
        check("bad3_err", 32'(rq.req_err), 1);
        check("bad3_ready", 32'(rq.req_ready), 1);
        check("bad3_mode", 32'(mode_cur), 1);
        check("bad3_fbdsel", 32'(fbdsel), 9);
        check("bad3_locked", 32'(locked), 1);
        tick(1);
        check("bad3_err_pulse", 32'(rq.req_err), 0);
        request(2'd2);
        check("bad2_err", 32'(rq.req_err), 1);
        check("bad2_pll_reset", 32'(pll_reset), 0);
        tick(1);
        check("bad2_locked", 32'(locked), 1);

        // Lock loss in RUN, then lock never returns
        pll_lock = 1'b0;
        tick(2);
        check("loss_locked_hold", 32'(locked), 1);
        tick(1);
        check("loss_locked", 32'(locked), 0);
        check("loss_vresetn", 32'(video_resetn), 0);
        check("loss_pll_reset_lag", 32'(pll_reset), 0);
        rises   = 0;
        fail_at = 0;
        prev    = pll_reset;
        for (int k = 1; k <= 170; k++) begin
            tick(1);
            if (pll_reset && !prev) begin
                if (rises < 3) rise_at[rises] = k;
                rises++;
            end
            if (fail && fail_at == 0) fail_at = k;
            prev = pll_reset;
        end
        check("retry_pulses", 32'(rises), 3);
        check("retry_rise1", 32'(rise_at[0]), 1);
        check("retry_rise2", 32'(rise_at[1]), 55);
        check("retry_rise3", 32'(rise_at[2]), 109);
        check("fail_edge", 32'(fail_at), 162);
        check("fail_ready", 32'(rq.req_ready), 1);
        check("fail_pll_reset", 32'(pll_reset), 0);
        check("fail_vresetn", 32'(video_resetn), 0);

        // Request from FAIL restarts, then async reset hits mid-STABLE
        request(2'd0);
        check("fail_clr", 32'(fail), 0);
        check("fail_req_mode", 32'(mode_cur), 0);
        check("fail_req_ready", 32'(rq.req_ready), 0);
        tick(1);
        check("fail_req_rst", 32'(pll_reset), 1);
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        check("stable_locked", 32'(locked), 0);
        check("stable_pll_reset", 32'(pll_reset), 0);
        #2 resetn = 1'b0;
        #1;
        reset_values("async");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
